// File: rtl/stp16_pkg.sv
// stp16_pkg: shared defaults and the frame-assembly state type for the STP16 pin-bus receiver.
package stp16_pkg;

   localparam int STP16_DEFAULT_WIDTH   = 64;
   localparam int STP16_MIN_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      EMPTY,
      SHIFTING,
      FULL,
      OVERLONG
   } stp16_state_e;

endpackage

// File: rtl/pin_synchronizer.sv
// pin_synchronizer: multi-flop synchronizer for one STP16 pin, async active-low reset to 0.
// With STP16_RECEIVER_GLITCH_FILTER_EN defined, a 2-sample agreement filter follows the chain.
module pin_synchronizer
   import stp16_pkg::*;
#(
   parameter int stages = STP16_MIN_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic level_o
);

   logic [stages-1:0] chain_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[stages-2:0], pin_i};
      end
   end

`ifdef STP16_RECEIVER_GLITCH_FILTER_EN
   logic prev_q;
   logic filt_q;
   logic filt_d;

   // The level only moves once the newest synchronized sample matches the one before it.
   always_comb begin
      filt_d = filt_q;
      if (chain_q[stages-1] == prev_q) begin
         filt_d = prev_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         prev_q <= chain_q[stages-1];
         filt_q <= filt_d;
      end
   end

   assign level_o = filt_d;
`else
   assign level_o = chain_q[stages-1];
`endif

endmodule

// File: rtl/stp16_receiver.sv
// stp16_receiver: deserializes the STP16 LED-driver pin bus into width-bit frames on a valid/ready port.
// Optional STP16_RECEIVER_GLITCH_FILTER_EN enables the per-pin glitch filter inside pin_synchronizer.
module stp16_receiver
   import stp16_pkg::*;
#(
   parameter int width       = STP16_DEFAULT_WIDTH,
   parameter int sync_stages = STP16_MIN_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stp16_clk,
   input  logic             stp16_sdi,
   input  logic             stp16_le,
   input  logic             stp16_noe,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [width-1:0] o_data,
   output logic             o_enable,
   output logic             o_frame_error,
   output logic             o_overrun
);

   localparam int STAGES = (sync_stages < STP16_MIN_SYNC_STAGES) ? STP16_MIN_SYNC_STAGES : sync_stages;
   localparam int CNT_W  = $clog2(width + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(width);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(width + 1);

   logic clkSync;
   logic sdiSync;
   logic leSync;
   logic noeSync;

   pin_synchronizer #(.stages(STAGES)) uClkSync (.clk(clk), .reset(reset), .pin_i(stp16_clk), .level_o(clkSync));
   pin_synchronizer #(.stages(STAGES)) uSdiSync (.clk(clk), .reset(reset), .pin_i(stp16_sdi), .level_o(sdiSync));
   pin_synchronizer #(.stages(STAGES)) uLeSync  (.clk(clk), .reset(reset), .pin_i(stp16_le),  .level_o(leSync));
   pin_synchronizer #(.stages(STAGES)) uNoeSync (.clk(clk), .reset(reset), .pin_i(stp16_noe), .level_o(noeSync));

   logic clkHist_q;
   logic sdiHist_q;
   logic leHist_q;
   logic shiftPulse_q;
   logic latchPulse_q;

   // Edge pulses are registered; sdi is taken from its history flop so it lines up with the shift pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clkHist_q    <= 1'b0;
         sdiHist_q    <= 1'b0;
         leHist_q     <= 1'b0;
         shiftPulse_q <= 1'b0;
         latchPulse_q <= 1'b0;
      end else begin
         clkHist_q    <= clkSync;
         sdiHist_q    <= sdiSync;
         leHist_q     <= leSync;
         shiftPulse_q <= clkSync & ~clkHist_q;
         latchPulse_q <= leSync & ~leHist_q;
      end
   end

   logic [width-1:0] shiftReg_q;
   logic [width-1:0] shiftReg_d;
   logic [CNT_W-1:0] bitCnt_q;
   logic [CNT_W-1:0] bitCnt_d;
   stp16_state_e     state_q;
   stp16_state_e     state_d;

   // Post-shift view: a latch in the same cycle as a shift judges the frame after that shift.
   always_comb begin
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      state_d    = state_q;
      if (shiftPulse_q) begin
         shiftReg_d = {shiftReg_q[width-2:0], sdiHist_q};
         if (bitCnt_q != CNT_MAX) begin
            bitCnt_d = bitCnt_q + 1'b1;
         end
         case (state_q)
            EMPTY, SHIFTING: state_d = (bitCnt_d == CNT_FULL) ? FULL : SHIFTING;
            default:         state_d = OVERLONG;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= EMPTY;
         shiftReg_q    <= '0;
         bitCnt_q      <= '0;
         o_valid       <= 1'b0;
         o_data        <= '0;
         o_enable      <= 1'b0;
         o_frame_error <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         o_frame_error <= 1'b0;
         o_overrun     <= 1'b0;
         o_enable      <= ~noeSync;
         shiftReg_q    <= shiftReg_d;
         if (o_valid && o_ready) begin
            o_valid <= 1'b0;
         end
         if (latchPulse_q) begin
            state_q  <= EMPTY;
            bitCnt_q <= '0;
            if (state_d == FULL) begin
               o_data    <= shiftReg_d;
               o_valid   <= 1'b1;
               o_overrun <= o_valid & ~o_ready;
            end else begin
               o_frame_error <= 1'b1;
            end
         end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
         end
      end
   end

endmodule

// File: tb/tb_stp16_receiver.sv
// tb_stp16_receiver: drives the STP16 pin bus, scoreboards frames on the valid/ready port and
// checks latency, frame errors, overrun and the enable path against its own expectations.
module tb_stp16_receiver;

   localparam int WIDTH = 64;
   localparam int SYNC  = 2;
`ifdef STP16_RECEIVER_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   localparam int PHASE = 3;
   localparam int NVEC  = 6;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               nbits;
      logic             expErr;
   } vec_t;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic stpClk = 1'b0;
   logic stpSdi = 1'b0;
   logic stpLe  = 1'b0;
   logic stpNoe = 1'b1;
   logic oReady = 1'b0;

   logic             oValid;
   logic [WIDTH-1:0] oData;
   logic             oEnable;
   logic             oFrameError;
   logic             oOverrun;

   int checks    = 0;
   int errors    = 0;
   int errPulses = 0;
   int ovrPulses = 0;
   logic [WIDTH-1:0] expQ[$];

   stp16_receiver #(.width(WIDTH), .sync_stages(SYNC)) dut (
      .clk(clk),
      .reset(reset),
      .stp16_clk(stpClk),
      .stp16_sdi(stpSdi),
      .stp16_le(stpLe),
      .stp16_noe(stpNoe),
      .o_valid(oValid),
      .o_ready(oReady),
      .o_data(oData),
      .o_enable(oEnable),
      .o_frame_error(oFrameError),
      .o_overrun(oOverrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor samples mid-cycle: counts pulses and scoreboards every valid/ready transfer.
   always @(negedge clk) begin
      #2;
      if (reset) begin
         if (oFrameError) errPulses++;
         if (oOverrun) ovrPulses++;
         if (oValid && oReady) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL transfer: unexpected frame %h with empty scoreboard", oData);
            end else begin
               checkOutput("transfer o_data", oData, expQ.pop_front());
            end
         end
      end
   end

   task automatic shiftBit(input logic b);
      @(negedge clk);
      stpSdi = b;
      repeat (PHASE) @(negedge clk);
      stpClk = 1'b1;
      repeat (PHASE) @(negedge clk);
      stpClk = 1'b0;
   endtask

   task automatic sendBits(input logic [WIDTH-1:0] d, input int n);
      logic [WIDTH-1:0] s;
      s = d;
      for (int i = 0; i < n; i++) begin
         shiftBit(s[WIDTH-1]);
         s = s << 1;
      end
   endtask

   task automatic pulseLe();
      @(negedge clk);
      stpLe = 1'b1;
      repeat (PHASE) @(negedge clk);
      stpLe = 1'b0;
      repeat (PHASE) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] d, input int n);
      sendBits(d, n);
      pulseLe();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[NVEC];
      int   errBase;
      int   ovrBase;
      logic sawEnable;

      vecs[0] = '{64'hA5A5_0F0F_1234_FFFF, 64, 1'b0};
      vecs[1] = '{64'h0000_0000_0000_0000, 63, 1'b1};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1};
      vecs[3] = '{64'h0123_4567_89AB_CDEF, 64, 1'b0};
      vecs[4] = '{64'h0000_0000_0000_0000, 0,  1'b1};
      vecs[5] = '{64'h8000_0000_0000_0001, 64, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset o_valid", 64'(oValid), 64'd0);
      checkOutput("reset o_data", oData, 64'd0);
      checkOutput("reset o_enable", 64'(oEnable), 64'd0);
      checkOutput("reset o_frame_error", 64'(oFrameError), 64'd0);
      checkOutput("reset o_overrun", 64'(oOverrun), 64'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Nominal frame: latency, hold while not ready, then handshake
      oReady  = 1'b0;
      errBase = errPulses;
      sendBits(64'hA5A5_0F0F_1234_FFFF, 64);
      @(negedge clk);
      stpLe = 1'b1;
      repeat (SYNC + 1 + FILT) @(posedge clk);
      #1 checkOutput("latency o_valid before", 64'(oValid), 64'd0);
      @(posedge clk);
      #1 checkOutput("latency o_valid at", 64'(oValid), 64'd1);
      checkOutput("nominal o_data", oData, 64'hA5A5_0F0F_1234_FFFF);
      repeat (PHASE) @(negedge clk);
      stpLe = 1'b0;
      repeat (10) @(negedge clk);
      #3;
      checkOutput("hold o_valid", 64'(oValid), 64'd1);
      checkOutput("hold o_data", oData, 64'hA5A5_0F0F_1234_FFFF);
      checkOutput("nominal frame_error count", 64'(errPulses - errBase), 64'd0);
      expQ.push_back(64'hA5A5_0F0F_1234_FFFF);
      @(negedge clk);
      oReady = 1'b1;
      @(negedge clk);
      #3;
      checkOutput("handshake o_valid cleared", 64'(oValid), 64'd0);
      checkOutput("handshake scoreboard drained", 64'(expQ.size()), 64'd0);

      // Table-driven frames with the sink always ready
      for (int i = 0; i < NVEC; i++) begin
         errBase = errPulses;
         if (!vecs[i].expErr) expQ.push_back(vecs[i].data);
         applyStimulus(vecs[i].data, vecs[i].nbits);
         repeat (3) @(negedge clk);
         #3;
         checkOutput($sformatf("vec%0d frame_error count", i), 64'(errPulses - errBase), 64'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d o_valid", i), 64'(oValid), 64'd0);
         checkOutput($sformatf("vec%0d scoreboard", i), 64'(expQ.size()), 64'd0);
      end

      // Overrun: second frame overwrites an unaccepted first frame
      @(negedge clk);
      oReady  = 1'b0;
      ovrBase = ovrPulses;
      expQ.push_back(64'h1);
      applyStimulus(64'h1, 64);
      #3 checkOutput("overrun first o_valid", 64'(oValid), 64'd1);
      expQ.push_back(64'h2);
      applyStimulus(64'h2, 64);
      #3;
      checkOutput("overrun pulse count", 64'(ovrPulses - ovrBase), 64'd1);
      checkOutput("overrun o_data", oData, 64'h2);
      checkOutput("overrun o_valid", 64'(oValid), 64'd1);
      void'(expQ.pop_front());
      @(negedge clk);
      oReady = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      checkOutput("overrun drained", 64'(expQ.size()), 64'd0);
      checkOutput("overrun o_valid cleared", 64'(oValid), 64'd0);

      // Transfer and new latch in the same cycle
      @(negedge clk);
      oReady  = 1'b0;
      ovrBase = ovrPulses;
      expQ.push_back(64'h3);
      applyStimulus(64'h3, 64);
      sendBits(64'h4, 64);
      @(negedge clk);
      stpLe = 1'b1;
      repeat (SYNC + 1 + FILT) @(negedge clk);
      oReady = 1'b1;
      @(negedge clk);
      oReady = 1'b0;
      #3;
      checkOutput("simultaneous o_valid", 64'(oValid), 64'd1);
      checkOutput("simultaneous o_data", oData, 64'h4);
      checkOutput("simultaneous first frame taken", 64'(expQ.size()), 64'd0);
      expQ.push_back(64'h4);
      repeat (PHASE) @(negedge clk);
      stpLe = 1'b0;
      repeat (PHASE) @(negedge clk);
      #3 checkOutput("simultaneous overrun count", 64'(ovrPulses - ovrBase), 64'd0);
      @(negedge clk);
      oReady = 1'b1;
      repeat (2) @(negedge clk);
      #3 checkOutput("simultaneous drained", 64'(expQ.size()), 64'd0);

      // Reset mid-frame discards the partial frame and clears a pending one
      @(negedge clk);
      oReady = 1'b0;
      applyStimulus(64'h5, 64);
      #3 checkOutput("pre-reset o_valid", 64'(oValid), 64'd1);
      sendBits(64'hFFFF_FFFF_FFFF_FFFF, 20);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("mid-reset o_valid", 64'(oValid), 64'd0);
      checkOutput("mid-reset o_data", oData, 64'd0);
      checkOutput("mid-reset o_frame_error", 64'(oFrameError), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      oReady  = 1'b1;
      errBase = errPulses;
      expQ.push_back(64'hDEAD_BEEF_CAFE_F00D);
      applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 64);
      repeat (3) @(negedge clk);
      #3;
      checkOutput("post-reset frame_error count", 64'(errPulses - errBase), 64'd0);
      checkOutput("post-reset scoreboard", 64'(expQ.size()), 64'd0);

      // Output enable follows inverted noe
      @(negedge clk);
      stpNoe = 1'b0;
      repeat (SYNC + FILT) @(posedge clk);
      #1 checkOutput("enable rise before", 64'(oEnable), 64'd0);
      @(posedge clk);
      #1 checkOutput("enable rise at", 64'(oEnable), 64'd1);
      @(negedge clk);
      stpNoe = 1'b1;
      repeat (SYNC + FILT) @(posedge clk);
      #1 checkOutput("enable fall before", 64'(oEnable), 64'd1);
      @(posedge clk);
      #1 checkOutput("enable fall at", 64'(oEnable), 64'd0);
`ifdef STP16_RECEIVER_GLITCH_FILTER_EN
      sawEnable = 1'b0;
      @(negedge clk);
      stpNoe = 1'b0;
      @(negedge clk);
      stpNoe = 1'b1;
      repeat (8) begin
         @(negedge clk);
         #1 sawEnable = sawEnable | oEnable;
      end
      checkOutput("enable glitch rejected", 64'(sawEnable), 64'd0);
`else
      sawEnable = 1'b0;
`endif

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stp16_receiver.md
Name: stp16_receiver

Overview:
Receive-side counterpart of the stp16cpc26 LED-driver serial transmitter. Samples the four STP16 pins (clk, sdi, le, noe) in the local clock domain and deserializes sdi into a width-bit frame. On each latch strobe it presents the frame on a valid/ready output. Used as a bench monitor for the level meter and as the input stage of a slave display board fed from the meter's LED bus.

Parameters:
width, 64, frame length in bits; must equal the transmitter's width.
sync_stages, 2, synchronizer flop count per input pin; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
stp16_clk  input  1  serial shift clock from the transmitter; asynchronous to clk.
stp16_sdi  input  1  serial data; sampled on stp16_clk rising edge.
stp16_le  input  1  latch enable; rising edge ends the frame.
stp16_noe  input  1  output enable, active-low.
o_valid  output  1  frame available.
o_ready  input  1  downstream accepts the frame.
o_data  output  width  latched frame; first bit shifted in is at o_data[width-1].
o_enable  output  1  synchronized, inverted stp16_noe.
o_frame_error  output  1  one-cycle pulse: latch with bit count != width.
o_overrun  output  1  one-cycle pulse: unaccepted frame overwritten.

Behaviour:
- Reset (reset=0, asynchronous): o_valid=0, o_data=0, o_enable=0, o_frame_error=0, o_overrun=0.
- Reset also clears the shift register, the bit counter, all synchronizer flops and the edge-history flops.
- Reset asserted mid-frame discards the partial frame.
- First edge after release: edge detectors compare against reset history 0. A pin already high at release produces one spurious rising edge.
- Pin inputs: each pin passes through sync_stages flops, then one history flop. Rising edge = sync & ~history.
- Input timing: stp16_clk high and low phases are each at least 2 clk periods. sdi is stable from one cycle before to one cycle after the stp16_clk rise.
- Shift: on a stp16_clk rising edge, shift_reg <= {shift_reg[width-2:0], sdi_sync}.
- Bit counter: on each shift, bit_cnt <= bit_cnt+1, saturating at width+1. Counter width is $clog2(width+2).
- FSM states:
  - EMPTY: bit_cnt==0.
  - SHIFTING: 0<bit_cnt<width.
  - FULL: bit_cnt==width.
  - OVERLONG: bit_cnt==width+1.
- FSM transitions:
  - Shift edges advance EMPTY -> SHIFTING -> FULL -> OVERLONG.
  - A le rising edge from any state returns to EMPTY.
- Latch, le rising edge in FULL: o_data <= shift_reg; o_valid <= 1.
- Latch, le rising edge in any other state: frame discarded, o_frame_error=1 for one cycle, o_data/o_valid unchanged.
- Latch in EMPTY is also a frame error. This covers a repeated le with no data.
- Shift and le rising in the same cycle: the shift happens first and counts toward the frame. The latch uses the post-shift count and data.
- Handshake: transfer occurs when o_valid && o_ready. o_valid is cleared the next cycle unless a new frame latches that cycle.
- o_data is stable while o_valid=1 and no latch occurs.
- Valid frame latched while o_valid=1 and o_ready=0: o_data overwritten with the new frame, o_valid stays 1, o_overrun=1 for one cycle.
- Valid frame latched in the same cycle as a transfer: new frame loaded, o_valid stays 1, no overrun.
- Latency: a le rising at the pin sets o_valid sync_stages+2 clk edges later.
- o_enable: equals ~noe_sync and follows a pin change after sync_stages+1 cycles. It does not gate data capture.

Optional Feature:
STP16_RECEIVER_GLITCH_FILTER_EN
- Defined: after the synchronizer, each pin feeds a 2-sample majority filter. The filtered level changes only when two consecutive synchronized samples agree.
  - Single-cycle glitches are rejected.
  - All pin-to-output latencies grow by 1 cycle.
  - Minimum stp16_clk phase becomes 3 clk periods.
- Undefined: no filter; synchronized samples drive the edge detectors directly.

Decomposition:
- Package stp16_pkg holds:
  - STP16_DEFAULT_WIDTH=64
  - STP16_MIN_SYNC_STAGES=2
  - FSM state enum {EMPTY, SHIFTING, FULL, OVERLONG}
- Sub-module pin_synchronizer (parameter stages, async active-low reset to 0) is instantiated once per pin.
- The glitch filter lives inside pin_synchronizer under the macro.

Test Plan:
- Reset: mid-frame after 20 shifts, pulse reset low -> all outputs 0. A following 64-bit frame latches correctly with no frame error.
- Nominal: shift 64'hA5A5_0F0F_1234_FFFF MSB first, then le pulse, with o_ready=0 -> o_valid=1 at sync_stages+2 cycles, o_data=64'hA5A5_0F0F_1234_FFFF, held stable; o_ready=1 -> o_valid=0 the next cycle.
- Frame error: 63 shifts then le -> o_frame_error one cycle, o_valid stays 0. 65 shifts then le -> same.
- Overrun: two full frames 64'h1 then 64'h2 with o_ready=0 -> o_overrun one cycle, o_data=64'h2, o_valid=1.
- Simultaneous: o_ready=1 in the cycle the second frame latches -> o_valid stays 1, o_data=second frame, o_overrun=0.
- Enable: toggle stp16_noe 1->0->1 -> o_enable 0->1->0, each change sync_stages+1 cycles after the pin; with the macro defined, a 1-cycle noe glitch leaves o_enable unchanged.
